// File: rtl/part_insp_pkg.sv
// Shared encoding and defaults for the part learn/inspect controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, default widths, NO_PART marker and match limits.
package part_insp_pkg;

  localparam int DEF_DATA_W   = 12;
  localparam int DEF_ADDR_W   = 10;
  localparam int DEF_NO_PART  = 882;
  localparam int DEF_TOL      = 4;
  localparam int DEF_MAX_MISS = 8;
  localparam int DEF_LEN_TOL  = 2;
  localparam int DEF_MEM_LAT  = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    L_WAIT = 3'd1,
    L_CAP  = 3'd2,
    I_WAIT = 3'd3,
    I_CMP  = 3'd4,
    DRAIN  = 3'd5,
    DONE   = 3'd6
  } state_t;

endpackage

// File: rtl/insp_delay_pipe.sv
// Delays a compare token {valid, sample, beyond_len} so it meets part_mem read data.
// Latency: DEPTH cycles from in_* to out_*.
// Backpressure: none; accepts a token every cycle, flush drops everything in flight.
// Ports: clk, rst_n, flush | in_vld/in_sample/in_beyond | out_vld/out_sample/out_beyond | any_vld
module insp_delay_pipe #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_sample,
  input  logic              in_beyond,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_sample,
  output logic              out_beyond,
  output logic              any_vld
);

  logic [DEPTH-1:0]  vld_q;
  logic [DEPTH-1:0]  bey_q;
  logic [DATA_W-1:0] smp_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      bey_q <= '0;
      for (int i = 0; i < DEPTH; i++) smp_q[i] <= '0;
    end else if (flush) begin
      vld_q <= '0;
      bey_q <= '0;
      for (int i = 0; i < DEPTH; i++) smp_q[i] <= '0;
    end else begin
      vld_q[0] <= in_vld;
      bey_q[0] <= in_beyond;
      smp_q[0] <= in_sample;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        bey_q[i] <= bey_q[i-1];
        smp_q[i] <= smp_q[i-1];
      end
    end
  end

  assign out_vld    = vld_q[DEPTH-1];
  assign out_beyond = bey_q[DEPTH-1];
  assign out_sample = smp_q[DEPTH-1];
  assign any_vld    = |vld_q;

endmodule

// File: rtl/part_inspect_ctrl.sv
// Sequences ccd_reader and part_mem: LEARN stores one width per scan line, INSPECT compares live widths to it.
// Latency: mem outputs 1 cycle after ccd_valid; compare retires MEM_LAT cycles later; result after pipe drains.
// Backpressure: none; ccd_valid may strobe every cycle, ccd_en gates the reader between runs.
// Ports: clk, rst_n | learn_req, inspect_req, abort | ccd_data/ccd_valid/ccd_en
//        mem_addr/mem_wdata/mem_wren/mem_rden/mem_q | part_len, busy | result_valid/result_pass/miss_cnt | err_ovf
module part_inspect_ctrl
  import part_insp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NO_PART  = DEF_NO_PART,
  parameter int TOL      = DEF_TOL,
  parameter int MAX_MISS = DEF_MAX_MISS,
  parameter int LEN_TOL  = DEF_LEN_TOL,
  parameter int MEM_LAT  = DEF_MEM_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              learn_req,
  input  logic              inspect_req,
  input  logic              abort,
  input  logic [DATA_W-1:0] ccd_data,
  input  logic              ccd_valid,
  output logic              ccd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  output logic              mem_rden,
  input  logic [DATA_W-1:0] mem_q,
  output logic [ADDR_W-1:0] part_len,
  output logic              busy,
  output logic              result_valid,
  output logic              result_pass,
  output logic [ADDR_W-1:0] miss_cnt,
  output logic              err_ovf
);

  localparam logic [DATA_W-1:0]        NO_PART_V  = DATA_W'(NO_PART);
  localparam logic signed [DATA_W:0]   TOL_V      = (DATA_W+1)'(TOL);
  localparam logic [ADDR_W-1:0]        MAX_MISS_V = ADDR_W'(MAX_MISS);
  localparam logic [ADDR_W+1:0]        LEN_TOL_V  = (ADDR_W+2)'(LEN_TOL);
  // Learn index of the last storable entry; the inspect line counter is one bit wider and saturates.
  localparam logic [ADDR_W:0]          IDX_LAST   = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0]          IDX_SAT    = '1;
  localparam logic [ADDR_W-1:0]        MISS_SAT   = '1;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic              ccd_en_d, mem_wren_d, mem_rden_d, res_vld_d, res_pass_d, err_ovf_d;
  logic [ADDR_W-1:0] mem_addr_d, part_len_d, miss_d;
  logic [DATA_W-1:0] mem_wdata_d;

  // Compare token issued alongside the read; flush drops it together with the pipe.
  logic              push_vld, push_beyond, flush;
  logic [DATA_W-1:0] push_sample;
  logic              front_vld, front_beyond;
  logic [DATA_W-1:0] front_sample;
  logic              pipe_vld, pipe_beyond, pipe_any;
  logic [DATA_W-1:0] pipe_sample;
  logic              cmp_busy;

  logic              is_line, is_no_part;
  logic signed [DATA_W:0] diff, adiff;
  logic              is_miss;
  logic [ADDR_W+1:0] lines_x, plen_x, len_diff;
  logic              verdict;

  assign is_no_part = ccd_valid && (ccd_data == NO_PART_V);
  assign is_line    = ccd_valid && (ccd_data != NO_PART_V) && (ccd_data != '0);

  insp_delay_pipe #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_LAT)
  ) u_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_vld     (front_vld),
    .in_sample  (front_sample),
    .in_beyond  (front_beyond),
    .out_vld    (pipe_vld),
    .out_sample (pipe_sample),
    .out_beyond (pipe_beyond),
    .any_vld    (pipe_any)
  );

  assign cmp_busy = front_vld | pipe_any;

  // Samples and reference are unsigned; one extra bit makes the difference signed without wrap.
  assign diff    = $signed({1'b0, pipe_sample}) - $signed({1'b0, mem_q});
  assign adiff   = diff[DATA_W] ? -diff : diff;
  assign is_miss = pipe_vld && (pipe_beyond || (adiff > TOL_V));

  assign lines_x  = {1'b0, idx_q};
  assign plen_x   = {2'b00, part_len};
  assign len_diff = (lines_x >= plen_x) ? (lines_x - plen_x) : (plen_x - lines_x);
  assign verdict  = (miss_cnt <= MAX_MISS_V) && (len_diff <= LEN_TOL_V);

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ccd_en_d    = ccd_en;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_wren_d  = 1'b0;
    mem_rden_d  = 1'b0;
    part_len_d  = part_len;
    err_ovf_d   = err_ovf;
    res_vld_d   = 1'b0;
    res_pass_d  = result_pass;
    miss_d      = miss_cnt;
    push_vld    = 1'b0;
    push_beyond = 1'b0;
    push_sample = '0;
    flush       = 1'b0;

    if (is_miss && (miss_cnt != MISS_SAT)) miss_d = miss_cnt + 1'b1;

    case (state_q)
      IDLE: begin
        if (learn_req) begin
          state_d   = L_WAIT;
          ccd_en_d  = 1'b1;
          err_ovf_d = 1'b0;
          idx_d     = '0;
        end else if (inspect_req) begin
          miss_d = '0;
          idx_d  = '0;
          if (part_len == '0) begin
            // Nothing learned: report fail without running the reader.
            state_d    = DONE;
            res_vld_d  = 1'b1;
            res_pass_d = 1'b0;
          end else begin
            state_d  = I_WAIT;
            ccd_en_d = 1'b1;
          end
        end
      end
      L_WAIT, L_CAP: begin
        if (is_line) begin
          mem_addr_d  = idx_q[ADDR_W-1:0];
          mem_wdata_d = ccd_data;
          mem_wren_d  = 1'b1;
          if (idx_q == IDX_LAST) begin
            // Memory full: the last slot is written but part_len saturates one below the slot count.
            err_ovf_d  = 1'b1;
            part_len_d = '1;
            ccd_en_d   = 1'b0;
            state_d    = IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = L_CAP;
          end
        end else if ((state_q == L_CAP) && is_no_part) begin
          part_len_d = idx_q[ADDR_W-1:0];
          ccd_en_d   = 1'b0;
          state_d    = IDLE;
        end
      end
      I_WAIT, I_CMP: begin
        if (is_line) begin
          state_d     = I_CMP;
          push_vld    = 1'b1;
          push_sample = ccd_data;
          if (idx_q < {1'b0, part_len}) begin
            mem_rden_d = 1'b1;
            mem_addr_d = idx_q[ADDR_W-1:0];
          end else begin
            push_beyond = 1'b1;
          end
          if (idx_q != IDX_SAT) idx_d = idx_q + 1'b1;
        end else if ((state_q == I_CMP) && is_no_part) begin
          ccd_en_d = 1'b0;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (!cmp_busy) begin
          state_d    = DONE;
          res_vld_d  = 1'b1;
          res_pass_d = verdict;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d     = IDLE;
      idx_d       = idx_q;
      ccd_en_d    = 1'b0;
      mem_wren_d  = 1'b0;
      mem_rden_d  = 1'b0;
      part_len_d  = part_len;
      err_ovf_d   = err_ovf;
      res_vld_d   = 1'b0;
      res_pass_d  = result_pass;
      miss_d      = miss_cnt;
      push_vld    = 1'b0;
      flush       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      ccd_en       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wren     <= 1'b0;
      mem_rden     <= 1'b0;
      part_len     <= '0;
      err_ovf      <= 1'b0;
      result_valid <= 1'b0;
      result_pass  <= 1'b0;
      miss_cnt     <= '0;
      front_vld    <= 1'b0;
      front_beyond <= 1'b0;
      front_sample <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ccd_en       <= ccd_en_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      mem_wren     <= mem_wren_d;
      mem_rden     <= mem_rden_d;
      part_len     <= part_len_d;
      err_ovf      <= err_ovf_d;
      result_valid <= res_vld_d;
      result_pass  <= res_pass_d;
      miss_cnt     <= miss_d;
      front_vld    <= push_vld;
      front_beyond <= push_beyond;
      front_sample <= push_sample;
    end
  end

endmodule

// File: tb/tb_part_inspect_ctrl.sv
// Scoreboard bench for part_inspect_ctrl with a 2-cycle-latency part_mem model.
// Latency: n/a.
// Backpressure: n/a.
module tb_part_inspect_ctrl;

  localparam logic [11:0] NO_PART  = 12'd882;
  localparam int          TOL      = 4;
  localparam int          MAX_MISS = 8;
  localparam int          LEN_TOL  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        learn_req = 1'b0, inspect_req = 1'b0, abort = 1'b0;
  logic [11:0] ccd_data = '0;
  logic        ccd_valid = 1'b0;
  logic        ccd_en, mem_wren, mem_rden, busy, result_valid, result_pass, err_ovf;
  logic [9:0]  mem_addr, part_len, miss_cnt;
  logic [11:0] mem_wdata, mem_q;

  always #10 clk = ~clk;

  part_inspect_ctrl dut (
    .clk(clk), .rst_n(rst_n), .learn_req(learn_req), .inspect_req(inspect_req), .abort(abort),
    .ccd_data(ccd_data), .ccd_valid(ccd_valid), .ccd_en(ccd_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_q(mem_q),
    .part_len(part_len), .busy(busy), .result_valid(result_valid), .result_pass(result_pass),
    .miss_cnt(miss_cnt), .err_ovf(err_ovf)
  );

  // part_mem model: address registered, then output registered -> q two cycles after address.
  logic [11:0] mem [1024];
  logic [11:0] q1, q2;
  always @(posedge clk) begin
    if (mem_wren) mem[mem_addr] <= mem_wdata;
    if (mem_rden) q1 <= mem[mem_addr];
    q2 <= q1;
  end
  assign mem_q = q2;

  int          n_checks = 0, n_fail = 0, res_seen = 0;
  logic [21:0] exp_wr[$];
  logic [9:0]  exp_rd[$];
  logic [10:0] exp_res[$];
  int          stim[$];
  int          ref_prof[$];
  int          exp_plen = 0;

  initial begin : monitor
    logic [21:0] ew;
    logic [9:0]  ea;
    logic [10:0] er;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_wren) begin
          n_checks++;
          if (exp_wr.size() == 0) begin
            n_fail++;
            $display("FAIL mem_write: unexpected write addr=%0d data=%0d, none required", mem_addr, mem_wdata);
          end else begin
            ew = exp_wr.pop_front();
            if ({mem_addr, mem_wdata} !== ew) begin
              n_fail++;
              $display("FAIL mem_write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                       mem_addr, mem_wdata, ew[21:12], ew[11:0]);
            end
          end
        end
        if (mem_rden) begin
          n_checks++;
          if (exp_rd.size() == 0) begin
            n_fail++;
            $display("FAIL mem_read: unexpected read addr=%0d, none required", mem_addr);
          end else begin
            ea = exp_rd.pop_front();
            if (mem_addr !== ea) begin
              n_fail++;
              $display("FAIL mem_read: got addr=%0d, required addr=%0d", mem_addr, ea);
            end
          end
        end
        if (result_valid) begin
          res_seen++;
          n_checks++;
          if (exp_res.size() == 0) begin
            n_fail++;
            $display("FAIL result: unexpected result_valid pass=%0b miss=%0d", result_pass, miss_cnt);
          end else begin
            er = exp_res.pop_front();
            if ({result_pass, miss_cnt} !== er) begin
              n_fail++;
              $display("FAIL result: got pass=%0b miss=%0d, required pass=%0b miss=%0d",
                       result_pass, miss_cnt, er[10], er[9:0]);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference verdict from the stored profile.
  function automatic logic [10:0] model_result(input int plen);
    int miss, n, d;
    miss = 0;
    n = 0;
    if (plen == 0) return 11'd0;
    foreach (stim[i]) begin
      if (stim[i] == 0 || stim[i] == int'(NO_PART)) continue;
      if (n >= plen) miss++;
      else begin
        d = stim[i] - ref_prof[n];
        if (d < 0) d = -d;
        if (d > TOL) miss++;
      end
      n++;
    end
    if (miss > 1023) miss = 1023;
    d = n - plen;
    if (d < 0) d = -d;
    return {((miss <= MAX_MISS) && (d <= LEN_TOL)), 10'(miss)};
  endfunction

  task automatic step(input logic v, input logic [11:0] d);
    ccd_valid = v;
    ccd_data  = d;
    @(negedge clk);
    ccd_valid = 1'b0;
    ccd_data  = '0;
  endtask

  task automatic pulse_req(input bit learn);
    if (learn) learn_req = 1'b1;
    else       inspect_req = 1'b1;
    @(negedge clk);
    learn_req   = 1'b0;
    inspect_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic drive_inspect(input bit b2b, output bit ok);
    int n;
    exp_res.push_back(model_result(exp_plen));
    n = 0;
    foreach (stim[i]) begin
      if (stim[i] != 0 && stim[i] != int'(NO_PART)) begin
        if (n < exp_plen) exp_rd.push_back(10'(n));
        n++;
      end
    end
    pulse_req(1'b0);
    step(1'b1, NO_PART);
    step(1'b1, NO_PART);
    foreach (stim[i]) begin
      step(1'b1, 12'(stim[i]));
      if (!b2b) step(1'b0, 12'd0);
    end
    step(1'b1, NO_PART);
    wait_idle(200, ok);
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_checks++;
    if ({busy, ccd_en, mem_addr, mem_wdata, mem_wren, mem_rden, part_len, result_valid,
         result_pass, miss_cnt, err_ovf} !== 49'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%0b ccd_en=%0b addr=%0d wdata=%0d wren=%0b rden=%0b len=%0d rv=%0b rp=%0b miss=%0d ovf=%0b, required all 0",
               busy, ccd_en, mem_addr, mem_wdata, mem_wren, mem_rden, part_len, result_valid,
               result_pass, miss_cnt, err_ovf);
    end
  endtask

  task automatic test_learn();
    exp_wr.push_back({10'd0, 12'd100});
    exp_wr.push_back({10'd1, 12'd101});
    exp_wr.push_back({10'd2, 12'd102});
    pulse_req(1'b1);
    n_checks++;
    if ({busy, ccd_en} !== 2'b11) begin
      n_fail++;
      $display("FAIL learn_start: busy=%0b ccd_en=%0b, required 1 1", busy, ccd_en);
    end
    step(1'b1, NO_PART);
    step(1'b1, NO_PART);
    step(1'b1, NO_PART);
    step(1'b1, 12'd100);
    n_checks++;
    if ({mem_wren, mem_addr, mem_wdata} !== {1'b1, 10'd0, 12'd100}) begin
      n_fail++;
      $display("FAIL learn_latency: wren=%0b addr=%0d data=%0d one cycle after sample, required 1 0 100",
               mem_wren, mem_addr, mem_wdata);
    end
    step(1'b0, 12'd0);
    step(1'b1, 12'd101);
    step(1'b1, 12'd0);
    step(1'b1, 12'd102);
    step(1'b1, NO_PART);
    n_checks++;
    if ({part_len, busy, ccd_en, err_ovf} !== {10'd3, 3'b000}) begin
      n_fail++;
      $display("FAIL learn_end: part_len=%0d busy=%0b ccd_en=%0b ovf=%0b, required 3 0 0 0",
               part_len, busy, ccd_en, err_ovf);
    end
    n_checks++;
    if (exp_wr.size() != 0) begin
      n_fail++;
      $display("FAIL learn_writes: %0d writes outstanding, required 0", exp_wr.size());
    end
    ref_prof = '{100, 101, 102};
    exp_plen = 3;
  endtask

  task automatic test_inspect_exact();
    bit ok;
    int r0;
    stim = '{100, 101, 102};
    r0 = res_seen;
    drive_inspect(1'b0, ok);
    n_checks++;
    if (!ok || (res_seen - r0) != 1) begin
      n_fail++;
      $display("FAIL exact_done: idle=%0b results=%0d, required 1 1", ok, res_seen - r0);
    end
    n_checks++;
    if ({result_pass, miss_cnt, 1'b0} !== {1'b1, 10'd0, 1'(exp_rd.size())}) begin
      n_fail++;
      $display("FAIL exact_verdict: pass=%0b miss=%0d reads_left=%0d, required 1 0 0",
               result_pass, miss_cnt, exp_rd.size());
    end
  endtask

  task automatic test_inspect_tol();
    bit ok;
    int r0;
    stim = '{104, 96, 120};
    r0 = res_seen;
    drive_inspect(1'b0, ok);
    n_checks++;
    if (!ok || (res_seen - r0) != 1) begin
      n_fail++;
      $display("FAIL tol_done: idle=%0b results=%0d, required 1 1", ok, res_seen - r0);
    end
    n_checks++;
    if ({result_pass, miss_cnt} !== {1'b1, 10'd2}) begin
      n_fail++;
      $display("FAIL tol_verdict: pass=%0b miss=%0d, required 1 2", result_pass, miss_cnt);
    end
  endtask

  task automatic test_inspect_long();
    bit ok;
    int r0;
    stim = '{100, 101, 102, 100, 101, 102};
    r0 = res_seen;
    drive_inspect(1'b1, ok);
    n_checks++;
    if (!ok || (res_seen - r0) != 1 || exp_rd.size() != 0) begin
      n_fail++;
      $display("FAIL long_done: idle=%0b results=%0d reads_left=%0d, required 1 1 0",
               ok, res_seen - r0, exp_rd.size());
    end
    n_checks++;
    if ({result_pass, miss_cnt} !== {1'b0, 10'd3}) begin
      n_fail++;
      $display("FAIL long_verdict: pass=%0b miss=%0d, required 0 3", result_pass, miss_cnt);
    end
  endtask

  task automatic test_len_edge();
    bit ok;
    stim = '{100, 101, 102, 100, 100};
    drive_inspect(1'b0, ok);
    n_checks++;
    if (!ok || {result_pass, miss_cnt} !== {1'b1, 10'd2}) begin
      n_fail++;
      $display("FAIL len_edge: idle=%0b pass=%0b miss=%0d, required 1 1 2", ok, result_pass, miss_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int r0;
    stim = '{100, 110, 0, 98};
    r0 = res_seen;
    drive_inspect(1'b1, ok);
    n_checks++;
    if (!ok || (res_seen - r0) != 1 || {result_pass, miss_cnt} !== {1'b1, 10'd1}) begin
      n_fail++;
      $display("FAIL b2b_verdict: idle=%0b results=%0d pass=%0b miss=%0d, required 1 1 1 1",
               ok, res_seen - r0, result_pass, miss_cnt);
    end
  endtask

  task automatic test_abort();
    int r0;
    r0 = res_seen;
    exp_rd.push_back(10'd0);
    exp_rd.push_back(10'd1);
    pulse_req(1'b0);
    step(1'b1, NO_PART);
    step(1'b1, 12'd100);
    step(1'b1, 12'd101);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if ({busy, ccd_en, mem_rden, mem_wren} !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_idle: busy=%0b ccd_en=%0b rden=%0b wren=%0b, required 0 0 0 0",
               busy, ccd_en, mem_rden, mem_wren);
    end
    step(1'b1, 12'd150);
    repeat (10) @(negedge clk);
    n_checks++;
    if ((res_seen - r0) != 0 || exp_rd.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_noresult: results=%0d reads_left=%0d busy=%0b, required 0 0 0",
               res_seen - r0, exp_rd.size(), busy);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    for (int i = 0; i < 1024; i++) exp_wr.push_back({10'(i), 12'(200 + i % 50)});
    pulse_req(1'b1);
    step(1'b1, NO_PART);
    for (int i = 0; i < 1025; i++) step(1'b1, 12'(200 + i % 50));
    step(1'b1, NO_PART);
    wait_idle(50, ok);
    n_checks++;
    if (!ok || {err_ovf, part_len} !== {1'b1, 10'd1023} || exp_wr.size() != 0) begin
      n_fail++;
      $display("FAIL overflow: idle=%0b ovf=%0b part_len=%0d writes_left=%0d, required 1 1 1023 0",
               ok, err_ovf, part_len, exp_wr.size());
    end
    pulse_req(1'b1);
    n_checks++;
    if ({err_ovf, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL ovf_clear: ovf=%0b busy=%0b after learn_req, required 0 1", err_ovf, busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if ({busy, ccd_en, part_len} !== {2'b00, 10'd1023}) begin
      n_fail++;
      $display("FAIL learn_abort: busy=%0b ccd_en=%0b part_len=%0d, required 0 0 1023",
               busy, ccd_en, part_len);
    end
  endtask

  task automatic test_reset_mid_learn();
    exp_wr.push_back({10'd0, 12'd300});
    exp_wr.push_back({10'd1, 12'd301});
    pulse_req(1'b1);
    step(1'b1, NO_PART);
    step(1'b1, 12'd300);
    step(1'b1, 12'd301);
    #5 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, ccd_en, mem_addr, mem_wdata, mem_wren, mem_rden, part_len, result_valid,
         result_pass, miss_cnt, err_ovf} !== 49'd0) begin
      n_fail++;
      $display("FAIL reset_mid_learn: busy=%0b ccd_en=%0b addr=%0d wdata=%0d wren=%0b rden=%0b len=%0d rv=%0b rp=%0b miss=%0d ovf=%0b, required all 0",
               busy, ccd_en, mem_addr, mem_wdata, mem_wren, mem_rden, part_len, result_valid,
               result_pass, miss_cnt, err_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_plen = 0;
    n_checks++;
    if (exp_wr.size() != 0) begin
      n_fail++;
      $display("FAIL reset_writes: %0d writes outstanding, required 0", exp_wr.size());
    end
  endtask

  task automatic test_empty_inspect();
    int r0;
    r0 = res_seen;
    exp_res.push_back({1'b0, 10'd0});
    pulse_req(1'b0);
    n_checks++;
    if ({result_valid, ccd_en} !== 2'b10) begin
      n_fail++;
      $display("FAIL empty_done: result_valid=%0b ccd_en=%0b, required 1 0", result_valid, ccd_en);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if ((res_seen - r0) != 1 || busy !== 1'b0 || ccd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_after: results=%0d busy=%0b ccd_en=%0b, required 1 0 0",
               res_seen - r0, busy, ccd_en);
    end
  endtask

  initial begin : main
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_learn();
    test_inspect_exact();
    test_inspect_tol();
    test_inspect_long();
    test_len_edge();
    test_back_to_back();
    test_abort();
    test_overflow();
    test_reset_mid_learn();
    test_empty_inspect();
    n_checks++;
    if (exp_res.size() != 0) begin
      n_fail++;
      $display("FAIL results_left: %0d results outstanding, required 0", exp_res.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
